// File: rtl/dj_ctrl_pkg.sv
// Shared types and constants for the dj stream refill controller.
// Control word layout: [0] channel, [8:1] burst length minus one, [15:9] zero.
package dj_ctrl_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned CW_CH_BIT  = 0;
  localparam int unsigned CW_LEN_LSB = 1;
  localparam int unsigned CW_LEN_W   = 8;

  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  localparam logic CH_LEFT  = 1'b0;
  localparam logic CH_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEL    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Assemble the control word announcing a burst on channel ch.
  function automatic logic [DATA_W-1:0] ctrl_word(input logic [CW_LEN_W-1:0] len_m1,
                                                  input logic                ch);
    logic [DATA_W-1:0] w;
    w                            = '0;
    w[CW_CH_BIT]                 = ch;
    w[CW_LEN_LSB +: CW_LEN_W]    = len_m1;
    return w;
  endfunction

endpackage

// File: rtl/dj_stream_refill_ctrl_if.sv
// Avalon-MM write master bundle toward the dj core's 16-bit slave port.
interface dj_stream_refill_ctrl_if;
  import dj_ctrl_pkg::*;

  logic              m_address;
  logic [DATA_W-1:0] m_writedata;
  logic              m_write;
  logic              m_waitrequest;

  modport master (
    output m_address,
    output m_writedata,
    output m_write,
    input  m_waitrequest
  );

  modport slave (
    input  m_address,
    input  m_writedata,
    input  m_write,
    output m_waitrequest
  );

endinterface

// File: rtl/dj_rr_arb2.sv
// Two-way round-robin arbiter: a lone request wins, a tie goes to the
// channel that was not served last.
module dj_rr_arb2
  import dj_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic [1:0] gnt_c_o
);

  always_comb begin
    gnt_c_o = 2'b00;
    case (req_i)
      2'b01:   gnt_c_o = 2'b01;
      2'b10:   gnt_c_o = 2'b10;
      2'b11:   gnt_c_o = (last_i == CH_LEFT) ? 2'b10 : 2'b01;
      default: gnt_c_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/dj_stream_refill_ctrl.sv
// Refill scheduler sharing the dj core's Avalon slave between the left and
// right deck sample sources. Optional zero-padding on starvation: DJ_ZERO_PAD_EN.
module dj_stream_refill_ctrl
  import dj_ctrl_pkg::*;
#(
  parameter int unsigned BURST_LEN = 64
`ifdef DJ_ZERO_PAD_EN
  , parameter int unsigned STARVE_LIMIT = 32
`endif
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset,
  input  logic                     irq_left,
  input  logic                     irq_right,
  input  logic [DATA_W-1:0]        left_data,
  input  logic                     left_valid,
  output logic                     left_ready,
  input  logic [DATA_W-1:0]        right_data,
  input  logic                     right_valid,
  output logic                     right_ready,
  dj_stream_refill_ctrl_if.master  m_bus,
  output logic                     busy,
  output logic                     underrun
);

  localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]    LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [CW_LEN_W-1:0] LEN_M1   = CW_LEN_W'(BURST_LEN - 1);

  state_e             state_q;
  logic               irq_l_q, irq_r_q;
  logic               pend_l_q, pend_r_q;
  logic               grant_q, last_q;
  logic               busy_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               rise_l_c, rise_r_c;
  logic [1:0]         gnt_c;
  logic               src_valid_c;
  logic [DATA_W-1:0]  src_data_c;
  logic               src_ready_c;
  logic               accept_c;
  logic               done_c;
  logic               pad_c;

  assign rise_l_c = irq_left  & ~irq_l_q;
  assign rise_r_c = irq_right & ~irq_r_q;
  assign done_c   = (state_q == DONE);

  dj_rr_arb2 u_arb (
    .req_i   ({pend_r_q, pend_l_q}),
    .last_i  (last_q),
    .gnt_c_o (gnt_c)
  );

  assign src_valid_c = (grant_q == CH_RIGHT) ? right_valid : left_valid;
  assign src_data_c  = (grant_q == CH_RIGHT) ? right_data  : left_data;

  // Bus side is combinational from the state register and the live source.
  always_comb begin
    m_bus.m_address   = ADDR_DATA;
    m_bus.m_writedata = '0;
    m_bus.m_write     = 1'b0;
    case (state_q)
      SEL: begin
        m_bus.m_address   = ADDR_CTRL;
        m_bus.m_writedata = ctrl_word(LEN_M1, grant_q);
        m_bus.m_write     = 1'b1;
      end
      STREAM: begin
        if (pad_c) begin
          m_bus.m_write = 1'b1;
        end else begin
          m_bus.m_writedata = src_data_c;
          m_bus.m_write     = src_valid_c;
        end
      end
      default: ;
    endcase
  end

  assign accept_c    = (state_q == STREAM) && m_bus.m_write && !m_bus.m_waitrequest;
  assign src_ready_c = (state_q == STREAM) && !pad_c && !m_bus.m_waitrequest;
  assign left_ready  = src_ready_c && (grant_q == CH_LEFT);
  assign right_ready = src_ready_c && (grant_q == CH_RIGHT);
  assign busy        = busy_q;

  // Scheduler FSM with edge detect, pending flags and burst counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= IDLE;
      irq_l_q  <= 1'b0;
      irq_r_q  <= 1'b0;
      pend_l_q <= 1'b0;
      pend_r_q <= 1'b0;
      grant_q  <= CH_LEFT;
      last_q   <= CH_RIGHT;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      irq_l_q  <= irq_left;
      irq_r_q  <= irq_right;
      // A fresh edge in the DONE cycle outranks the clear.
      pend_l_q <= rise_l_c | (pend_l_q & ~(done_c & (grant_q == CH_LEFT)));
      pend_r_q <= rise_r_c | (pend_r_q & ~(done_c & (grant_q == CH_RIGHT)));
      case (state_q)
        IDLE: begin
          if (gnt_c != 2'b00) begin
            grant_q <= gnt_c[1];
            last_q  <= gnt_c[1];
            busy_q  <= 1'b1;
            state_q <= SEL;
          end
        end
        SEL: begin
          if (!m_bus.m_waitrequest) begin
            state_q <= STREAM;
          end
        end
        STREAM: begin
          if (accept_c) begin
            if (cnt_q == LAST_CNT) begin
              cnt_q   <= '0;
              state_q <= DONE;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DJ_ZERO_PAD_EN
  localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic                pad_q;
  logic                underrun_q;
  logic [STARVE_W-1:0] starve_q;

  // Starvation watchdog: after STARVE_LIMIT empty cycles, pad the burst with zeros.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      pad_q      <= 1'b0;
      underrun_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (state_q != STREAM) begin
        pad_q    <= 1'b0;
        starve_q <= '0;
      end else if (!pad_q) begin
        if (src_valid_c) begin
          starve_q <= '0;
        end else if (starve_q == STARVE_W'(STARVE_LIMIT - 1)) begin
          pad_q      <= 1'b1;
          underrun_q <= 1'b1;
          starve_q   <= '0;
        end else begin
          starve_q <= starve_q + STARVE_W'(1);
        end
      end
    end
  end

  assign pad_c    = pad_q;
  assign underrun = underrun_q;
`else
  assign pad_c    = 1'b0;
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_dj_stream_refill_ctrl.sv
// Directed-sequence bench with randomized source/stall stimulus; expected bus
// traffic is built as "control word + next BURST_LEN samples" per served refill.
module tb_dj_stream_refill_ctrl;

  localparam int unsigned BL    = 64;
  localparam int unsigned SRC_N = 2048;

  typedef struct packed {
    logic        addr;
    logic [15:0] data;
  } txn_t;

  logic        clk;
  logic        reset_reset;
  logic        irq_left, irq_right;
  logic [15:0] left_data, right_data;
  logic        left_valid, right_valid;
  logic        left_ready, right_ready;
  logic        busy, underrun;

  dj_stream_refill_ctrl_if bus ();

  dj_stream_refill_ctrl #(.BURST_LEN(BL)) dut (
    .clk_clk     (clk),
    .reset_reset (reset_reset),
    .irq_left    (irq_left),
    .irq_right   (irq_right),
    .left_data   (left_data),
    .left_valid  (left_valid),
    .left_ready  (left_ready),
    .right_data  (right_data),
    .right_valid (right_valid),
    .right_ready (right_ready),
    .m_bus       (bus),
    .busy        (busy),
    .underrun    (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [15:0] lsrc [SRC_N];
  logic [15:0] rsrc [SRC_N];
  int lidx = 0, ridx = 0;
  int mptr_l = 0, mptr_r = 0;

  logic rst_v = 1'b1, irq_l_v = 1'b0, irq_r_v = 1'b0;
  int   lv_pct = 100, rv_pct = 100, wr_pct = 0, wr_force = 0;
  int   l_stop = SRC_N - 1;
  int   cyc = 0, both_rdy = 0, n_unf = 0, unf_cyc = -1;

  txn_t got[$];
  txn_t exp[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs after the falling edge, observe just before the rising edge.
  task automatic cycle();
    @(negedge clk);
    reset_reset = rst_v;
    irq_left    = irq_l_v;
    irq_right   = irq_r_v;
    if (wr_force > 0) begin
      bus.m_waitrequest = 1'b1;
      wr_force--;
    end else begin
      bus.m_waitrequest = (wr_pct != 0) && (int'($urandom_range(99)) < wr_pct);
    end
    left_valid  = (lidx < l_stop) && (int'($urandom_range(99)) < lv_pct);
    right_valid = (int'($urandom_range(99)) < rv_pct);
    left_data   = lsrc[lidx];
    right_data  = rsrc[ridx];
    #1;
    if (bus.m_write && !bus.m_waitrequest) got.push_back(txn_t'{bus.m_address, bus.m_writedata});
    if (left_ready && right_ready) both_rdy++;
    if (left_ready && left_valid) lidx++;
    if (right_ready && right_valid) ridx++;
    if (underrun) begin
      n_unf++;
      if (unf_cyc < 0) unf_cyc = cyc;
    end
    cyc++;
  endtask

  task automatic run_until_quiet(input int max_cyc, input string tag);
    int quiet = 0;
    int n = 0;
    while (quiet < 5 && n < max_cyc) begin
      cycle();
      n++;
      quiet = busy ? 0 : quiet + 1;
    end
    chk({tag, " settle timeout"}, 32'(n >= max_cyc), 32'd0);
  endtask

  task automatic run_until_writes(input int nw, input int max_cyc, input string tag);
    int n = 0;
    while (got.size() < nw && n < max_cyc) begin
      cycle();
      n++;
    end
    chk({tag, " write-count timeout"}, 32'(got.size()), 32'(nw));
  endtask

  // Reference refill: control word (length-1 shifted past the channel bit) then BL samples.
  task automatic exp_burst(input logic ch);
    exp.push_back(txn_t'{1'b1, 16'((BL - 1) * 2 + int'(ch))});
    for (int k = 0; k < int'(BL); k++) begin
      if (ch) exp.push_back(txn_t'{1'b0, rsrc[mptr_r++]});
      else    exp.push_back(txn_t'{1'b0, lsrc[mptr_l++]});
    end
  endtask

  task automatic check_txns(input string tag);
    chk({tag, " txn count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      chk($sformatf("%s txn[%0d]", tag, i), 32'(got[i]), 32'(exp[i]));
    chk({tag, " left consumed"},  32'(lidx), 32'(mptr_l));
    chk({tag, " right consumed"}, 32'(ridx), 32'(mptr_r));
    got.delete();
    exp.delete();
  endtask

  task automatic do_reset();
    rst_v = 1'b1;
    cycle();
    cycle();
    rst_v = 1'b0;
    got.delete();
  endtask

  initial begin
    int t0, g0, l0, stall_bad, busy_seen;
    reset_reset = 1'b1;
    irq_left = 1'b0; irq_right = 1'b0;
    left_valid = 1'b0; right_valid = 1'b0;
    left_data = '0; right_data = '0;
    bus.m_waitrequest = 1'b0;
    for (int i = 0; i < int'(SRC_N); i++) begin
      lsrc[i] = 16'($urandom_range(1, 65535));
      rsrc[i] = 16'($urandom_range(1, 65535));
    end

    // Reset state
    do_reset();
    chk("reset m_write",  32'(bus.m_write), 32'd0);
    chk("reset busy",     32'(busy),        32'd0);
    chk("reset l_ready",  32'(left_ready),  32'd0);
    chk("reset r_ready",  32'(right_ready), 32'd0);
    chk("reset underrun", 32'(underrun),    32'd0);

    // A: single left refill, source always valid; latency and DONE timing
    irq_l_v = 1'b1;
    cycle();
    t0 = cyc;
    run_until_writes(1, 10, "A ctrl");
    chk("A irq-to-ctrl latency", 32'(cyc - t0), 32'd2);
    chk("A ctrl addr/data", 32'(got[0]), 32'h1007E);
    cycle();
    chk("A first sample latency", 32'(got.size()), 32'd2);
    run_until_writes(BL + 1, 200, "A burst");
    cycle();
    chk("A DONE busy", 32'(busy), 32'd1);
    chk("A DONE no write", 32'(bus.m_write), 32'd0);
    cycle();
    chk("A idle busy", 32'(busy), 32'd0);
    irq_l_v = 1'b0;
    run_until_quiet(50, "A");
    exp_burst(1'b0);
    check_txns("A");

    // B: simultaneous irqs after reset, random valid and stalls; left first
    do_reset();
    lv_pct = 50; rv_pct = 50; wr_pct = 20;
    irq_l_v = 1'b1; irq_r_v = 1'b1;
    cycle();
    irq_l_v = 1'b0; irq_r_v = 1'b0;
    run_until_quiet(3000, "B");
    exp_burst(1'b0);
    exp_burst(1'b1);
    check_txns("B");

    // C: three-cycle stall mid-burst holds the transfer
    lv_pct = 100; wr_pct = 0;
    irq_l_v = 1'b1;
    run_until_writes(31, 100, "C pre-stall");
    irq_l_v = 1'b0;
    g0 = got.size(); l0 = lidx; stall_bad = 0;
    wr_force = 3;
    for (int k = 0; k < 3; k++) begin
      cycle();
      if (left_ready) stall_bad++;
    end
    chk("C stall writes",  32'(got.size()), 32'(g0));
    chk("C stall consume", 32'(lidx),       32'(l0));
    chk("C stall ready",   32'(stall_bad),  32'd0);
    run_until_quiet(400, "C");
    exp_burst(1'b0);
    check_txns("C");

    // D: right irq re-rises in the DONE cycle of its own burst
    lv_pct = 60; rv_pct = 60;
    irq_r_v = 1'b1;
    cycle();
    irq_r_v = 1'b0;
    run_until_writes(BL + 1, 600, "D first");
    irq_r_v = 1'b1;
    cycle();
    chk("D DONE busy", 32'(busy), 32'd1);
    chk("D DONE no write", 32'(bus.m_write), 32'd0);
    run_until_quiet(800, "D");
    irq_r_v = 1'b0;
    exp_burst(1'b1);
    exp_burst(1'b1);
    check_txns("D");

    // E: reset at sample 10 abandons the burst and drops the pending right request
    lv_pct = 100; rv_pct = 100;
    irq_l_v = 1'b1; irq_r_v = 1'b1;
    cycle();
    irq_l_v = 1'b0; irq_r_v = 1'b0;
    run_until_writes(11, 100, "E pre-reset");
    rst_v = 1'b1;
    cycle();
    got.delete();
    rst_v = 1'b0;
    cycle();
    chk("E post-reset m_write", 32'(bus.m_write), 32'd0);
    chk("E post-reset busy",    32'(busy),        32'd0);
    chk("E post-reset l_ready", 32'(left_ready),  32'd0);
    busy_seen = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (busy) busy_seen++;
    end
    chk("E no writes after reset", 32'(got.size()), 32'd0);
    chk("E stays idle",            32'(busy_seen),  32'd0);
    mptr_l = lidx;
    mptr_r = ridx;

`ifdef DJ_ZERO_PAD_EN
    // F: source starves after 20 samples; remainder padded with zeros
    l_stop = lidx + 20;
    irq_l_v = 1'b1;
    cycle();
    irq_l_v = 1'b0;
    run_until_writes(21, 100, "F valid part");
    t0 = cyc;
    run_until_quiet(400, "F");
    chk("F underrun pulses", 32'(n_unf), 32'd1);
    chk("F idle cycles before pad", 32'(unf_cyc - t0), 32'd32);
    exp.push_back(txn_t'{1'b1, 16'((BL - 1) * 2)});
    for (int k = 0; k < 20; k++) exp.push_back(txn_t'{1'b0, lsrc[mptr_l++]});
    for (int k = 20; k < int'(BL); k++) exp.push_back(txn_t'{1'b0, 16'h0000});
    check_txns("F");
`else
    chk("underrun never pulses", 32'(n_unf), 32'd0);
`endif

    chk("non-granted ready held low", 32'(both_rdy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
